mlp_feature_sequencer: RTL and testbench
========================================

# mlp_feature_sequencer

Sequential front/back-end for the combinational printed MLP regressor stage.
- Accepts 4-bit sensor features one per handshake and packs them into the 16-bit feature vector driving the MLP's `inp`.
- Waits a programmable settle time for the slow printed-logic path, then captures the 19-bit MLP `out`.
- Presents the result on a valid/ready output port.
- Sits directly upstream of the MLP (drives its inputs) and samples its result.

## Interface
- `N_FEAT`, 4, features per frame
- `FEAT_W`, 4, bits per feature
- `OUT_W`, 19, MLP result width
- `SETTLE_CYCLES`, 3, cycles allowed for MLP combinational settling; legal range 1..255
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  feature valid
- `s_ready`  out  1  sequencer can accept a feature
- `s_data`  in  FEAT_W  feature value, unsigned
- `s_last`  in  1  marks final feature of frame (used only with `FEAT_LAST_CHECK_EN`)
- `mlp_inp`  out  N_FEAT*FEAT_W  packed vector to MLP, feature k at bits [k*FEAT_W +: FEAT_W]
- `mlp_out`  in  OUT_W  MLP result, unsigned (post-ReLU)
- `m_valid`  out  1  result valid
- `m_ready`  in  1  consumer accepts result
- `m_data`  out  OUT_W  registered MLP result
- `busy`  out  1  high in SETTLE or OUT
- `frame_err`  out  1  one-cycle pulse on discarded frame

## Operation
- States:
  - LOAD: `s_ready`=1, `m_valid`=0.
  - SETTLE: `s_ready`=0.
  - OUT: `m_valid`=1, `s_ready`=0.
- LOAD:
  - Each accepted feature (`s_valid && s_ready`) is written into slot `idx` of the `mlp_inp` register; `idx` increments (width clog2(N_FEAT)).
  - First feature of a frame lands in bits [FEAT_W-1:0].
  - Accept with `idx`==N_FEAT-1: `idx` wraps to 0; settle counter loads SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - Counter decrements each cycle; `mlp_inp` is frozen.
  - At counter==0: `m_data` <= `mlp_out`; go to OUT.
- OUT:
  - `m_data` is held stable while `m_valid` && !`m_ready`.
  - On `m_valid && m_ready`: go to LOAD.
- `mlp_inp` is never cleared between frames; slots are overwritten as new features arrive.
- No arithmetic on data; `mlp_out` is captured bit-exact, no truncation.
- Reset mid-operation: state returns immediately to LOAD, `idx` goes to 0, the partial frame is lost, and any pending result is dropped.

## Timing
- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `mlp_inp`=0, `busy`=0, `frame_err`=0, `idx`=0, state LOAD.
- Latency: last feature accepted at edge T; `mlp_inp` is complete after T. Capture occurs at edge T+SETTLE_CYCLES; `m_valid` is high from that edge.
- Throughput: the next frame's first feature can be accepted the cycle after the `m_valid && m_ready` edge. Minimum frame period is N_FEAT+SETTLE_CYCLES+1 cycles.
- `s_ready` and `m_valid` are registered state decodes with no combinational path from `s_valid` or `m_ready`.
- Once asserted, `m_valid` stays high until handshake.

## Configuration
- Macro: `FEAT_LAST_CHECK_EN`.
- Defined: `s_last` is checked on every accepted feature.
  - Error cases: `s_last`=1 with `idx`<N_FEAT-1, or `s_last`=0 with `idx`==N_FEAT-1.
  - On error: the frame is discarded, `idx` goes to 0, state stays LOAD, and `frame_err` pulses for one cycle on the following cycle.
  - Features already written remain in `mlp_inp` but are never captured.
- Undefined: `s_last` is ignored and `frame_err` is tied to 0.

## Test plan
- Reset, then features 0,0,0,0 with the 4-input regressor stage attached:
  - `mlp_inp`=0x0000.
  - `m_valid` rises exactly 3 cycles after the 4th accept.
  - `m_data`=19066.
- Features 15,15,0,0: `mlp_inp`=0x00FF, `m_data`=894.
- Backpressure: hold `m_ready`=0 for 10 cycles.
  - `m_valid` and `m_data` remain stable.
  - `s_ready`=0 throughout.
  - After `m_ready`=1, `s_ready`=1 on the next cycle.
- Interleaved `s_valid` gaps (valid every other cycle): `idx` advances only on handshakes and the final vector is correct. Also sweep SETTLE_CYCLES=1 to confirm 1-cycle capture.
- `FEAT_LAST_CHECK_EN`, `s_last`=1 on the 2nd feature:
  - One `frame_err` pulse; no `m_valid`.
  - The next clean 4-feature frame produces the correct result.
- Assert `rst_n`=0 during SETTLE: all outputs return to reset values asynchronously, and no stale result appears after release.

Source files
------------

// File: rtl/mlp_feature_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mlp_feature_sequencer
// Description : Sequential wrapper around a combinational printed MLP stage.
//               Packs FEAT_W-bit features into the MLP input vector, waits
//               SETTLE_CYCLES for the slow logic to settle, captures the MLP
//               result and offers it on a valid/ready port.
//               Optional macro FEAT_LAST_CHECK_EN enables s_last frame checks.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_feature_sequencer #(
   parameter int N_FEAT        = 4,
   parameter int FEAT_W        = 4,
   parameter int OUT_W         = 19,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [FEAT_W-1:0]        s_data,
   input  logic                     s_last,
   output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
   input  logic [OUT_W-1:0]         mlp_out,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [OUT_W-1:0]         m_data,
   output logic                     busy,
   output logic                     frame_err
);

   localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam int VEC_W = N_FEAT * FEAT_W;

   localparam logic [1:0] c_st_load   = 2'd0;
   localparam logic [1:0] c_st_settle = 2'd1;
   localparam logic [1:0] c_st_out    = 2'd2;

   localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(N_FEAT - 1);
   localparam logic [7:0]       c_settle_init = 8'(SETTLE_CYCLES - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [7:0]       r_cnt;
   logic [VEC_W-1:0] r_mlp_inp;
   logic [OUT_W-1:0] r_m_data;

   logic w_accept;
   logic w_last_slot;
   logic w_last_err;
   logic w_frame_done;

   assign w_accept     = s_valid && s_ready;
   assign w_last_slot  = (r_idx == c_last_idx);
   assign w_frame_done = w_accept && w_last_slot && !w_last_err;

`ifdef FEAT_LAST_CHECK_EN
   logic r_frame_err;

   // A frame is bad when s_last disagrees with the slot being written
   assign w_last_err = w_accept && (s_last != w_last_slot);

   // One-cycle error pulse in the cycle following the offending accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_last_err;
      end
   end

   assign frame_err = r_frame_err;
`else
   logic w_unused_last;

   assign w_last_err    = 1'b0;
   assign w_unused_last = s_last;
   assign frame_err     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_load;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_load: begin
            if (w_frame_done) begin
               w_state_nxt = c_st_settle;
            end
         end
         c_st_settle: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = c_st_out;
            end
         end
         c_st_out: begin
            if (m_ready) begin
               w_state_nxt = c_st_load;
            end
         end
         default: begin
            w_state_nxt = c_st_load;
         end
      endcase
   end

   // Handshake and status outputs decoded purely from the state register
   always_comb begin
      s_ready = 1'b0;
      m_valid = 1'b0;
      busy    = 1'b0;
      case (r_state)
         c_st_load: begin
            s_ready = 1'b1;
         end
         c_st_settle: begin
            busy = 1'b1;
         end
         c_st_out: begin
            m_valid = 1'b1;
            busy    = 1'b1;
         end
         default: begin
            s_ready = 1'b0;
         end
      endcase
   end

   // Feature packing, settle countdown and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx     <= '0;
         r_cnt     <= '0;
         r_mlp_inp <= '0;
         r_m_data  <= '0;
      end else begin
         if (w_accept) begin
            r_mlp_inp[r_idx*FEAT_W +: FEAT_W] <= s_data;
            if (w_last_slot || w_last_err) begin
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
            if (w_frame_done) begin
               r_cnt <= c_settle_init;
            end
         end
         if (r_state == c_st_settle) begin
            if (r_cnt != 8'd0) begin
               r_cnt <= r_cnt - 8'd1;
            end else begin
               r_m_data <= mlp_out;
            end
         end
      end
   end

   assign mlp_inp = r_mlp_inp;
   assign m_data  = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_mlp_feature_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_feature_sequencer
// Description : Directed self-checking bench. Two sequencers (settle 3 and
//               settle 1) share one stimulus stream; each drives a stand-in
//               MLP model whose two reference points match the regressor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_feature_sequencer;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic [3:0]  s_data;
   logic        s_last;
   logic        m_ready;

   logic        s_ready0, m_valid0, busy0, frame_err0;
   logic [15:0] mlp_inp0;
   logic [18:0] mlp_out0, m_data0;
   logic        s_ready1, m_valid1, busy1, frame_err1;
   logic [15:0] mlp_inp1;
   logic [18:0] mlp_out1, m_data1;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Stand-in for the attached regressor: exact at the two known points
   function automatic logic [18:0] mlp_model(input logic [15:0] v);
      case (v)
         16'h0000: mlp_model = 19'd19066;
         16'h00FF: mlp_model = 19'd894;
         default:  mlp_model = {3'b011, v ^ 16'h5A5A};
      endcase
   endfunction

   assign mlp_out0 = mlp_model(mlp_inp0);
   assign mlp_out1 = mlp_model(mlp_inp1);

   mlp_feature_sequencer #(.N_FEAT(4), .FEAT_W(4), .OUT_W(19), .SETTLE_CYCLES(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0),
      .s_data(s_data), .s_last(s_last), .mlp_inp(mlp_inp0), .mlp_out(mlp_out0),
      .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
      .busy(busy0), .frame_err(frame_err0)
   );

   mlp_feature_sequencer #(.N_FEAT(4), .FEAT_W(4), .OUT_W(19), .SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1),
      .s_data(s_data), .s_last(s_last), .mlp_inp(mlp_inp1), .mlp_out(mlp_out1),
      .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
      .busy(busy1), .frame_err(frame_err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send one 4-feature frame; gap inserts an idle cycle after each accept
   task automatic send_frame(input logic [15:0] feats, input bit gap, output int t_last);
      t_last = 0;
      for (int k = 0; k < 4; k++) begin
         int n;
         n = 0;
         s_valid = 1'b1;
         s_data  = feats[k*4 +: 4];
         s_last  = (k == 3);
         while (!s_ready0 && n < 50) begin
            tick();
            n++;
         end
         if (n >= 50) check("s_ready_timeout", 32'd0, 32'd1);
         tick();
         t_last  = cyc;
         s_valid = 1'b0;
         s_last  = 1'b0;
         if (gap && k != 3) tick();
      end
   endtask

   // Wait for both results; returns edges after last accept for each DUT
   task automatic wait_result(input int t_last, output int lat0, output int lat1);
      lat0 = -1;
      lat1 = m_valid1 ? 0 : -1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (m_valid1 && lat1 < 0) lat1 = cyc - t_last;
         if (m_valid0 && lat0 < 0) lat0 = cyc - t_last;
         if (lat0 >= 0) break;
      end
      if (lat0 < 0) check("m_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic handshake();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   initial begin
      int t_last, lat0, lat1;
      logic [15:0] vec;
      rst_n   = 1'b1;
      s_valid = 1'b0;
      s_data  = 4'd0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_s_ready",   {31'd0, s_ready0}, 32'd1);
      check("rst_m_valid",   {31'd0, m_valid0}, 32'd0);
      check("rst_m_data",    {13'd0, m_data0},  32'd0);
      check("rst_mlp_inp",   {16'd0, mlp_inp0}, 32'd0);
      check("rst_busy",      {31'd0, busy0},    32'd0);
      check("rst_frame_err", {31'd0, frame_err0}, 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Frame 0,0,0,0: latency and known result
      send_frame(16'h0000, 1'b0, t_last);
      check("f0_m_valid_at_accept", {31'd0, m_valid0}, 32'd0);
      check("f0_busy", {31'd0, busy0}, 32'd1);
      wait_result(t_last, lat0, lat1);
      check("f0_mlp_inp", {16'd0, mlp_inp0}, 32'h0000);
      check("f0_latency_s3", lat0, 32'd3);
      check("f0_latency_s1", lat1, 32'd1);
      check("f0_m_data", {13'd0, m_data0}, 32'd19066);
      check("f0_m_data_s1", {13'd0, m_data1}, 32'd19066);
      check("f0_s_ready_out", {31'd0, s_ready0}, 32'd0);
      handshake();
      check("f0_s_ready_after_hs", {31'd0, s_ready0}, 32'd1);
      check("f0_m_valid_after_hs", {31'd0, m_valid0}, 32'd0);

      // Frame 15,15,0,0 with gaps, then 10 cycles of backpressure
      send_frame(16'h00FF, 1'b1, t_last);
      wait_result(t_last, lat0, lat1);
      check("f1_mlp_inp", {16'd0, mlp_inp0}, 32'h00FF);
      check("f1_latency", lat0, 32'd3);
      check("f1_m_data", {13'd0, m_data0}, 32'd894);
      s_valid = 1'b1;
      s_data  = 4'd7;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_hold", {11'd0, m_valid0, s_ready0, m_data0}, {11'd0, 1'b1, 1'b0, 19'd894});
      end
      s_valid = 1'b0;
      check("bp_mlp_inp_frozen", {16'd0, mlp_inp0}, 32'h00FF);
      handshake();
      check("bp_s_ready_after_hs", {31'd0, s_ready0}, 32'd1);

      // Frame 1,2,3,4 with gaps
      vec = 16'h4321;
      send_frame(vec, 1'b1, t_last);
      wait_result(t_last, lat0, lat1);
      check("f2_mlp_inp", {16'd0, mlp_inp0}, {16'd0, vec});
      check("f2_m_data", {13'd0, m_data0}, {13'd0, mlp_model(vec)});
      check("f2_m_data_s1", {13'd0, m_data1}, {13'd0, mlp_model(vec)});
      handshake();

`ifdef FEAT_LAST_CHECK_EN
      // Premature s_last on the second feature
      s_valid = 1'b1; s_data = 4'd5; s_last = 1'b0;
      tick();
      s_data = 4'd6; s_last = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      check("ferr_pulse", {31'd0, frame_err0}, 32'd1);
      tick();
      check("ferr_pulse_end", {31'd0, frame_err0}, 32'd0);
      repeat (4) tick();
      check("ferr_no_result", {30'd0, m_valid0, s_ready0}, 32'd1);
`else
      check("ferr_tied_low", {31'd0, frame_err0}, 32'd0);
`endif
      vec = 16'h6789;
      send_frame(vec, 1'b0, t_last);
      wait_result(t_last, lat0, lat1);
      check("f3_m_data", {13'd0, m_data0}, {13'd0, mlp_model(vec)});
      check("f3_latency", lat0, 32'd3);
      handshake();

      // Asynchronous reset during SETTLE
      send_frame(16'hDCBA, 1'b0, t_last);
      tick();
      check("rs_busy_before", {31'd0, busy0}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rs_s_ready",  {31'd0, s_ready0}, 32'd1);
      check("rs_m_valid",  {30'd0, m_valid0, m_valid1}, 32'd0);
      check("rs_m_data",   {13'd0, m_data0},  32'd0);
      check("rs_mlp_inp",  {16'd0, mlp_inp0}, 32'd0);
      check("rs_busy",     {31'd0, busy0},    32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rs_no_stale", {29'd0, m_valid0, m_valid1, busy0}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
